// File: rtl/hilo_seq.sv
// HI/LO operation sequencer for EX: two-phase multiply-accumulate and a
// start/ready handshake with the external iterative divider.
module hilo_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  op_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic [63:0] hilo_old_i,
    input  logic [5:0]  stall_i,
    input  logic        annul_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        div_annul_o,
    output logic        stallreq_o,
    output logic [63:0] hilo_o,
    output logic        hilo_valid_o
);

    localparam logic [1:0] OP_MADD = 2'b01;
    localparam logic [1:0] OP_MSUB = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MAC2     = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] mul_r;
    logic [63:0] res_r;
    logic        sub_r;
    logic        load_mul;
    logic        load_res;
    logic [63:0] res_next;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic        ex_held;
    logic        unused_stall_bits;

    assign ex_held           = stall_i[3];
    assign unused_stall_bits = ^{stall_i[5:4], stall_i[2:0]};

    // Extending to 64 bits first lets one multiplier serve both signednesses;
    // only the low 64 bits of the product are kept.
    always_comb begin
        a_ext   = signed_i ? {{32{opdata1_i[31]}}, opdata1_i} : {32'd0, opdata1_i};
        b_ext   = signed_i ? {{32{opdata2_i[31]}}, opdata2_i} : {32'd0, opdata2_i};
        product = a_ext * b_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mul_r <= 64'd0;
            res_r <= 64'd0;
            sub_r <= 1'b0;
        end else begin
            state <= state_next;
            if (load_mul) begin
                mul_r <= product;
                sub_r <= (op_i == OP_MSUB);
            end
            if (load_res) begin
                res_r <= res_next;
            end
        end
    end

    // Annul overrides everything, including a ready pulse in the same cycle.
    always_comb begin
        state_next    = state;
        load_mul      = 1'b0;
        load_res      = 1'b0;
        res_next      = 64'd0;
        div_start_o   = 1'b0;
        div_signed_o  = 1'b0;
        div_opdata1_o = 32'd0;
        div_opdata2_o = 32'd0;
        div_annul_o   = 1'b0;
        stallreq_o    = 1'b0;
        hilo_o        = 64'd0;
        hilo_valid_o  = 1'b0;

        if (rst) begin
            state_next = IDLE;
        end else if (annul_i) begin
            state_next  = IDLE;
            div_annul_o = (state == DIV_WAIT);
        end else begin
            case (state)
                IDLE: begin
                    if (op_i == OP_MADD || op_i == OP_MSUB) begin
                        load_mul   = 1'b1;
                        stallreq_o = 1'b1;
                        state_next = MAC2;
                    end else if (op_i == OP_DIV) begin
                        stallreq_o = 1'b1;
                        if (opdata2_i != 32'd0) begin
                            div_start_o   = 1'b1;
                            div_signed_o  = signed_i;
                            div_opdata1_o = opdata1_i;
                            div_opdata2_o = opdata2_i;
                            state_next    = DIV_WAIT;
                        end else begin
                            load_res   = 1'b1;
                            res_next   = 64'd0;
                            state_next = DONE;
                        end
                    end
                end
                MAC2: begin
                    // Combinational so late forwarding into hilo_old_i is honoured.
                    hilo_o       = sub_r ? (hilo_old_i - mul_r) : (hilo_old_i + mul_r);
                    hilo_valid_o = 1'b1;
                    if (!ex_held) begin
                        state_next = IDLE;
                    end
                end
                DIV_WAIT: begin
                    stallreq_o = 1'b1;
                    if (div_ready_i) begin
                        load_res   = 1'b1;
                        res_next   = div_result_i;
                        state_next = DONE;
                    end
                end
                DONE: begin
                    hilo_o       = res_r;
                    hilo_valid_o = 1'b1;
                    if (!ex_held) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_seq.sv
// Randomized scoreboard bench for hilo_seq with a behavioural divider model
// and a reference model for multiply-accumulate and division.
module tb_hilo_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  op_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] hilo_old_i;
    logic [5:0]  stall_i;
    logic        annul_i;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic        div_start_o;
    logic        div_signed_o;
    logic [31:0] div_opdata1_o;
    logic [31:0] div_opdata2_o;
    logic        div_annul_o;
    logic        stallreq_o;
    logic [63:0] hilo_o;
    logic        hilo_valid_o;

    int          total = 0;
    int          bad = 0;
    int          starts = 0;
    int          div_lat = 1;
    logic [63:0] exp_q[$];

    logic        dm_sgn;
    logic [31:0] dm_a;
    logic [31:0] dm_b;
    int          dm_n;

    hilo_seq dut (
        .clk(clk), .rst(rst), .op_i(op_i), .signed_i(signed_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hilo_old_i(hilo_old_i),
        .stall_i(stall_i), .annul_i(annul_i), .div_ready_i(div_ready_i),
        .div_result_i(div_result_i), .div_start_o(div_start_o),
        .div_signed_o(div_signed_o), .div_opdata1_o(div_opdata1_o),
        .div_opdata2_o(div_opdata2_o), .div_annul_o(div_annul_o),
        .stallreq_o(stallreq_o), .hilo_o(hilo_o), .hilo_valid_o(hilo_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] ref_mac(input logic sub, input logic s, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] old);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            p = sa * sb;
        end else begin
            ua = a;
            ub = b;
            p = ua * ub;
        end
        return sub ? old - p : old + p;
    endfunction

    task automatic check_output(input string name, input logic [64:0] act, input logic [64:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: the final result cycle is the valid cycle with EX not held.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (div_start_o) starts++;
                if (hilo_valid_o && !stall_i[3]) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_valid: got hilo_valid=1 expected 0 (hilo=%h)", hilo_o);
                    end else begin
                        check_output("hilo_result", {1'b0, hilo_o}, {1'b0, exp_q.pop_front()});
                        check_output("stallreq_when_valid", {64'd0, stallreq_o}, 65'd0);
                    end
                end
            end
        end
    end

    // Divider model: answers from the operands the DUT hands it.
    initial begin
        div_ready_i  = 1'b0;
        div_result_i = 64'd0;
        forever begin
            @(negedge clk);
            if (div_start_o && !rst) begin
                dm_sgn = div_signed_o;
                dm_a   = div_opdata1_o;
                dm_b   = div_opdata2_o;
                dm_n   = div_lat;
                repeat (dm_n) @(posedge clk);
                #1;
                div_ready_i  = 1'b1;
                div_result_i = ref_div(dm_sgn, dm_a, dm_b);
                @(posedge clk);
                #1;
                div_ready_i  = 1'b0;
                div_result_i = {$urandom, $urandom};
            end
        end
    end

    // Issues one op at posedge+1 and holds it until the result cycle ends.
    task automatic apply_stimulus(input logic [1:0] op, input logic s, input logic [31:0] a,
                                  input logic [31:0] b_in, input logic [63:0] old,
                                  input logic [63:0] old_late, input int lat, input int hold,
                                  input string tag);
        logic [31:0] b;
        logic [63:0] exp;
        logic [63:0] cur;
        int          n;
        int          want;
        int          start0;
        bit          st_ok;
        b = b_in;
        if (s && op == 2'b11 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
        exp = (op == 2'b11) ? ref_div(s, a, b) : ref_mac(op == 2'b10, s, a, b, (hold > 0) ? old_late : old);
        want = (op == 2'b11 && b != 32'd0) ? lat + 1 : 1;
        div_lat    = lat;
        start0     = starts;
        op_i       = op;
        signed_i   = s;
        opdata1_i  = a;
        opdata2_i  = b;
        hilo_old_i = old;
        stall_i    = (hold > 0) ? 6'b001000 : 6'b000000;
        exp_q.push_back(exp);
        n = 0;
        st_ok = 1'b1;
        @(negedge clk);
        while (!hilo_valid_o && n < 200) begin
            if (!stallreq_o) st_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        check_output({tag, "_latency"}, 65'(n), 65'(want));
        check_output({tag, "_stallreq_busy"}, {64'd0, st_ok}, 65'd1);
        if (!hilo_valid_o) exp_q.delete();
        for (int i = 0; i < hold; i++) begin
            cur = (op == 2'b11) ? exp : ref_mac(op == 2'b10, s, a, b, hilo_old_i);
            check_output({tag, "_held"}, {hilo_valid_o, hilo_o}, {1'b1, cur});
            @(posedge clk);
            #1;
            hilo_old_i = old_late;
            if (i == hold - 1) stall_i = 6'b000000;
            @(negedge clk);
        end
        check_output({tag, "_starts"}, 65'(starts - start0), (op == 2'b11 && b != 32'd0) ? 65'd1 : 65'd0);
        @(posedge clk);
        #1;
        op_i    = 2'b00;
        stall_i = 6'b000000;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_b;
        int          r_hold;

        rst          = 1'b1;
        op_i         = 2'b11;
        signed_i     = 1'b1;
        opdata1_i    = 32'd7;
        opdata2_i    = 32'd2;
        hilo_old_i   = 64'h1234;
        stall_i      = 6'b000000;
        annul_i      = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_outputs",
            {div_start_o, div_signed_o, div_annul_o, stallreq_o, hilo_valid_o, hilo_o[59:0]}, 65'd0);
        check_output("reset_div_ops", {1'b0, div_opdata1_o, div_opdata2_o}, 65'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        op_i = 2'b00;
        @(posedge clk);
        #1;

        apply_stimulus(2'b01, 1'b1, 32'd3, 32'd2 + 32'd2, 64'h5, 64'h5, 1, 0, "madd");
        apply_stimulus(2'b10, 1'b1, 32'hFFFF_FFFF, 32'd2, 64'd0, 64'd0, 1, 0, "msub");
        apply_stimulus(2'b10, 1'b0, 32'hFFFF_FFFF, 32'd2, 64'd0, 64'd0, 1, 0, "msubu");
        apply_stimulus(2'b11, 1'b1, 32'd7, 32'd2, 64'd0, 64'd0, 34, 0, "div7_2");
        apply_stimulus(2'b11, 1'b0, 32'd7, 32'd2, 64'd0, 64'd0, 1, 0, "divu_fast");
        apply_stimulus(2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2, 64'd0, 64'd0, 3, 0, "div_neg");
        apply_stimulus(2'b11, 1'b1, 32'd9, 32'd0, 64'd0, 64'd0, 1, 0, "div_zero");
        apply_stimulus(2'b01, 1'b1, 32'd6, 32'd7, 64'd100, 64'h0000_0001_0000_0000, 1, 3, "mac_stall");
        apply_stimulus(2'b11, 1'b0, 32'd100, 32'd9, 64'd0, 64'd0, 2, 2, "div_stall");

        // Annul in the fifth cycle of a divide; the late ready must be ignored.
        div_lat   = 34;
        op_i      = 2'b11;
        signed_i  = 1'b1;
        opdata1_i = 32'd7;
        opdata2_i = 32'd2;
        repeat (5) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(negedge clk);
        check_output("annul_outputs", {61'd0, div_annul_o, stallreq_o, hilo_valid_o, div_start_o}, 65'b1000);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        op_i    = 2'b00;
        @(negedge clk);
        check_output("annul_idle", {63'd0, stallreq_o, hilo_valid_o}, 65'd0);
        repeat (40) @(posedge clk);
        #1;
        apply_stimulus(2'b01, 1'b0, 32'd10, 32'd20, 64'd1, 64'd1, 1, 0, "madd_after_annul");

        // Reset while waiting on the divider.
        div_lat   = 20;
        op_i      = 2'b11;
        opdata2_i = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_mid_div",
            {div_start_o, div_signed_o, div_annul_o, stallreq_o, hilo_valid_o, hilo_o[59:0]}, 65'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        op_i = 2'b00;
        @(negedge clk);
        check_output("rst_then_idle", {63'd0, stallreq_o, hilo_valid_o}, 65'd0);
        repeat (25) @(posedge clk);
        #1;

        for (int k = 0; k < 40; k++) begin
            r_op   = 2'($urandom_range(1, 3));
            r_b    = ($urandom % 4 == 0) ? ($urandom % 8) : $urandom;
            r_hold = ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
            apply_stimulus(r_op, 1'($urandom % 2), $urandom, r_b, {$urandom, $urandom},
                           {$urandom, $urandom}, int'($urandom_range(1, 40)), r_hold, "rand");
        end

        repeat (3) @(posedge clk);
        check_output("queue_drained", 65'(exp_q.size()), 65'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
